// File: rtl/reg_file_pkg.sv
// Shared defaults and address-width helper for the two-read / one-write register file.
package reg_file_pkg;

    localparam int DEFAULT_N     = 16;
    localparam int DEFAULT_DEPTH = 8;

    // Smallest w such that 2**w >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reservation,
// cleared by write; a reservation wins over a write to the same register.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_enable,
    input  logic [AW-1:0]    set_addr,
    input  logic             clear_enable,
    input  logic [AW-1:0]    clear_addr,
    output logic [DEPTH-1:0] busy
);

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic set_hit;
            logic clear_hit;

            assign set_hit   = set_enable && (set_addr == IDX);
            assign clear_hit = clear_enable && (clear_addr == IDX);
            // Set is checked first so a new reservation survives a same-cycle write.
            assign busy_next[gi] = set_hit ? 1'b1 : (clear_hit ? 1'b0 : busy_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with two registered read ports, one write port, write-to-read
// bypass and a pending-write scoreboard reported per read as a ready flag.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_enable,
    input  logic [AW-1:0]    read_addr1,
    input  logic [AW-1:0]    read_addr2,
    output logic [N-1:0]     read_data1,
    output logic [N-1:0]     read_data2,
    output logic             read_ready1,
    output logic             read_ready2,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_addr,
    input  logic [N-1:0]     write_data,
    input  logic             rsv_enable,
    input  logic [AW-1:0]    rsv_addr,
    output logic [DEPTH-1:0] busy
);

    logic [N-1:0] regs_reg [DEPTH];

    logic [N-1:0] read_data1_reg, read_data2_reg;
    logic [N-1:0] read_data1_next, read_data2_next;
    logic         read_ready1_reg, read_ready2_reg;
    logic         read_ready1_next, read_ready2_next;

    logic         wr_hit1, wr_hit2, rsv_hit1, rsv_hit2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (write_enable) begin
            regs_reg[write_addr] <= write_data;
        end
    end

    assign wr_hit1  = write_enable && (write_addr == read_addr1);
    assign wr_hit2  = write_enable && (write_addr == read_addr2);
    assign rsv_hit1 = rsv_enable && (rsv_addr == read_addr1);
    assign rsv_hit2 = rsv_enable && (rsv_addr == read_addr2);

    // A same-cycle write makes the captured value final unless it is re-reserved.
    always_comb begin
        read_data1_next  = wr_hit1 ? write_data : regs_reg[read_addr1];
        read_data2_next  = wr_hit2 ? write_data : regs_reg[read_addr2];
        read_ready1_next = wr_hit1 ? !rsv_hit1 : !busy[read_addr1];
        read_ready2_next = wr_hit2 ? !rsv_hit2 : !busy[read_addr2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data1_reg  <= '0;
            read_data2_reg  <= '0;
            read_ready1_reg <= 1'b1;
            read_ready2_reg <= 1'b1;
        end else if (read_enable) begin
            read_data1_reg  <= read_data1_next;
            read_data2_reg  <= read_data2_next;
            read_ready1_reg <= read_ready1_next;
            read_ready2_reg <= read_ready2_next;
        end
    end

    assign read_data1  = read_data1_reg;
    assign read_data2  = read_data2_reg;
    assign read_ready1 = read_ready1_reg;
    assign read_ready2 = read_ready2_reg;

    reg_scoreboard #(
        .DEPTH(DEPTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_enable  (rsv_enable),
        .set_addr    (rsv_addr),
        .clear_enable(write_enable),
        .clear_addr  (write_addr),
        .busy        (busy)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: default 16x8 instance plus a 32x16 instance.
module tb_reg_file_2r1w;

    logic        clk;
    logic        rst;

    logic        read_enable;
    logic [2:0]  read_addr1, read_addr2;
    logic [15:0] read_data1, read_data2;
    logic        read_ready1, read_ready2;
    logic        write_enable;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic        rsv_enable;
    logic [2:0]  rsv_addr;
    logic [7:0]  busy;

    logic        w_read_enable;
    logic [3:0]  w_read_addr1, w_read_addr2;
    logic [31:0] w_read_data1, w_read_data2;
    logic        w_read_ready1, w_read_ready2;
    logic        w_write_enable;
    logic [3:0]  w_write_addr;
    logic [31:0] w_write_data;
    logic        w_rsv_enable;
    logic [3:0]  w_rsv_addr;
    logic [15:0] w_busy;

    int passed;
    int total;

    reg_file_2r1w u_dut (
        .clk         (clk),
        .rst         (rst),
        .read_enable (read_enable),
        .read_addr1  (read_addr1),
        .read_addr2  (read_addr2),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .read_ready1 (read_ready1),
        .read_ready2 (read_ready2),
        .write_enable(write_enable),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .rsv_enable  (rsv_enable),
        .rsv_addr    (rsv_addr),
        .busy        (busy)
    );

    reg_file_2r1w #(
        .N    (32),
        .DEPTH(16)
    ) u_dut32 (
        .clk         (clk),
        .rst         (rst),
        .read_enable (w_read_enable),
        .read_addr1  (w_read_addr1),
        .read_addr2  (w_read_addr2),
        .read_data1  (w_read_data1),
        .read_data2  (w_read_data2),
        .read_ready1 (w_read_ready1),
        .read_ready2 (w_read_ready2),
        .write_enable(w_write_enable),
        .write_addr  (w_write_addr),
        .write_data  (w_write_data),
        .rsv_enable  (w_rsv_enable),
        .rsv_addr    (w_rsv_addr),
        .busy        (w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read_enable  = 1'b0;
        write_enable = 1'b0;
        rsv_enable   = 1'b0;
    endtask

    task automatic test_reset();
        #7;
        total++;
        if (busy !== 8'h00 || read_data1 !== 16'h0 || read_data2 !== 16'h0 ||
            read_ready1 !== 1'b1 || read_ready2 !== 1'b1) begin
            $display("FAIL reset_hold: busy=%h d1=%h d2=%h r1=%b r2=%b, expected 00/0000/0000/1/1",
                     busy, read_data1, read_data2, read_ready1, read_ready2);
        end else passed++;
        rst = 1'b0;
        tick();
        read_enable = 1'b1; read_addr1 = 3'd0; read_addr2 = 3'd7;
        tick();
        read_enable = 1'b0;
        total++;
        if (read_data1 !== 16'h0000 || read_data2 !== 16'h0000 ||
            read_ready1 !== 1'b1 || read_ready2 !== 1'b1 || busy !== 8'h00) begin
            $display("FAIL reset_read: d1=%h d2=%h r1=%b r2=%b busy=%h, expected 0000/0000/1/1/00",
                     read_data1, read_data2, read_ready1, read_ready2, busy);
        end else passed++;
        $display("test_reset: read r0/r7 after reset -> %h %h", read_data1, read_data2);
    endtask

    task automatic test_write_read();
        write_enable = 1'b1; write_addr = 3'd3; write_data = 16'hBEEF;
        tick();
        write_enable = 1'b0;
        read_enable = 1'b1; read_addr1 = 3'd3; read_addr2 = 3'd3;
        tick();
        total++;
        if (read_data1 !== 16'hBEEF || read_data2 !== 16'hBEEF ||
            read_ready1 !== 1'b1 || read_ready2 !== 1'b1) begin
            $display("FAIL write_read: d1=%h d2=%h r1=%b r2=%b, expected BEEF/BEEF/1/1",
                     read_data1, read_data2, read_ready1, read_ready2);
        end else passed++;
        read_enable = 1'b0; read_addr1 = 3'd0; read_addr2 = 3'd7;
        tick();
        total++;
        if (read_data1 !== 16'hBEEF || read_data2 !== 16'hBEEF) begin
            $display("FAIL read_hold: d1=%h d2=%h, expected BEEF/BEEF", read_data1, read_data2);
        end else passed++;
        $display("test_write_read: r3 -> %h %h (held)", read_data1, read_data2);
    endtask

    task automatic test_bypass();
        write_enable = 1'b1; write_addr = 3'd5; write_data = 16'h1234;
        read_enable = 1'b1; read_addr1 = 3'd5; read_addr2 = 3'd3;
        tick();
        idle();
        total++;
        if (read_data1 !== 16'h1234 || read_ready1 !== 1'b1 || read_data2 !== 16'hBEEF) begin
            $display("FAIL bypass: d1=%h r1=%b d2=%h, expected 1234/1/BEEF",
                     read_data1, read_ready1, read_data2);
        end else passed++;
        $display("test_bypass: write r5=1234 with read r5 -> %h", read_data1);
    endtask

    task automatic test_scoreboard();
        rsv_enable = 1'b1; rsv_addr = 3'd2;
        tick();
        idle();
        total++;
        if (busy !== 8'h04) begin
            $display("FAIL rsv_set: busy=%h, expected 04", busy);
        end else passed++;
        read_enable = 1'b1; read_addr1 = 3'd2; read_addr2 = 3'd5;
        tick();
        idle();
        total++;
        if (read_ready1 !== 1'b0 || read_data1 !== 16'h0000 ||
            read_ready2 !== 1'b1 || read_data2 !== 16'h1234) begin
            $display("FAIL read_busy: r1=%b d1=%h r2=%b d2=%h, expected 0/0000/1/1234",
                     read_ready1, read_data1, read_ready2, read_data2);
        end else passed++;
        // Write and re-reserve r2 in the same cycle while reading it.
        write_enable = 1'b1; write_addr = 3'd2; write_data = 16'h00AA;
        rsv_enable = 1'b1; rsv_addr = 3'd2;
        read_enable = 1'b1; read_addr1 = 3'd2;
        tick();
        idle();
        total++;
        if (busy !== 8'h04 || read_data1 !== 16'h00AA || read_ready1 !== 1'b0) begin
            $display("FAIL rsv_wins: busy=%h d1=%h r1=%b, expected 04/00AA/0",
                     busy, read_data1, read_ready1);
        end else passed++;
        // Re-reserve a busy register while writing a non-busy one.
        rsv_enable = 1'b1; rsv_addr = 3'd2;
        write_enable = 1'b1; write_addr = 3'd7; write_data = 16'h0777;
        tick();
        idle();
        total++;
        if (busy !== 8'h04) begin
            $display("FAIL rsv_again: busy=%h, expected 04", busy);
        end else passed++;
        write_enable = 1'b1; write_addr = 3'd2; write_data = 16'h00AB;
        rsv_enable = 1'b1; rsv_addr = 3'd4;
        read_enable = 1'b1; read_addr1 = 3'd2; read_addr2 = 3'd7;
        tick();
        idle();
        total++;
        if (busy !== 8'h10 || read_data1 !== 16'h00AB || read_ready1 !== 1'b1 ||
            read_data2 !== 16'h0777 || read_ready2 !== 1'b1) begin
            $display("FAIL split_addr: busy=%h d1=%h r1=%b d2=%h r2=%b, expected 10/00AB/1/0777/1",
                     busy, read_data1, read_ready1, read_data2, read_ready2);
        end else passed++;
        write_enable = 1'b1; write_addr = 3'd4; write_data = 16'h4444;
        tick();
        idle();
        total++;
        if (busy !== 8'h00) begin
            $display("FAIL write_clear: busy=%h, expected 00", busy);
        end else passed++;
        $display("test_scoreboard: final busy=%h", busy);
    endtask

    task automatic test_async_reset();
        write_enable = 1'b1; write_addr = 3'd6; write_data = 16'hFFFF;
        tick();
        idle();
        rsv_enable = 1'b1; rsv_addr = 3'd1;
        read_enable = 1'b1; read_addr1 = 3'd6; read_addr2 = 3'd6;
        tick();
        idle();
        total++;
        if (busy !== 8'h02 || read_data1 !== 16'hFFFF) begin
            $display("FAIL pre_reset: busy=%h d1=%h, expected 02/FFFF", busy, read_data1);
        end else passed++;
        // Mid-cycle reset, with a write and reservation that must be discarded.
        write_enable = 1'b1; write_addr = 3'd6; write_data = 16'h5555;
        rsv_enable = 1'b1; rsv_addr = 3'd3;
        #3 rst = 1'b1;
        #1;
        total++;
        if (busy !== 8'h00 || read_data1 !== 16'h0 || read_data2 !== 16'h0 ||
            read_ready1 !== 1'b1 || read_ready2 !== 1'b1) begin
            $display("FAIL async_reset: busy=%h d1=%h d2=%h r1=%b r2=%b, expected 00/0000/0000/1/1",
                     busy, read_data1, read_data2, read_ready1, read_ready2);
        end else passed++;
        tick();
        idle();
        #3 rst = 1'b0;
        read_enable = 1'b1; read_addr1 = 3'd6; read_addr2 = 3'd3;
        tick();
        idle();
        total++;
        if (read_data1 !== 16'h0000 || read_data2 !== 16'h0000 || busy !== 8'h00 ||
            read_ready2 !== 1'b1) begin
            $display("FAIL after_reset: d1=%h d2=%h busy=%h r2=%b, expected 0000/0000/00/1",
                     read_data1, read_data2, busy, read_ready2);
        end else passed++;
        $display("test_async_reset: r6 after reset -> %h", read_data1);
    endtask

    task automatic test_wide();
        w_write_enable = 1'b1; w_write_addr = 4'd15; w_write_data = 32'hDEADBEEF;
        tick();
        w_write_enable = 1'b0;
        w_read_enable = 1'b1; w_read_addr1 = 4'd15; w_read_addr2 = 4'd15;
        tick();
        total++;
        if (w_read_data1 !== 32'hDEADBEEF || w_read_data2 !== 32'hDEADBEEF ||
            w_read_ready1 !== 1'b1 || w_read_ready2 !== 1'b1) begin
            $display("FAIL wide_read: d1=%h d2=%h r1=%b r2=%b, expected DEADBEEF/DEADBEEF/1/1",
                     w_read_data1, w_read_data2, w_read_ready1, w_read_ready2);
        end else passed++;
        w_read_enable = 1'b0; w_read_addr1 = 4'd0;
        tick();
        total++;
        if (w_read_data1 !== 32'hDEADBEEF) begin
            $display("FAIL wide_hold: d1=%h, expected DEADBEEF", w_read_data1);
        end else passed++;
        w_write_enable = 1'b1; w_write_addr = 4'd5; w_write_data = 32'h12345678;
        w_read_enable = 1'b1; w_read_addr1 = 4'd5; w_read_addr2 = 4'd15;
        w_rsv_enable = 1'b1; w_rsv_addr = 4'd15;
        tick();
        w_write_enable = 1'b0; w_read_enable = 1'b0; w_rsv_enable = 1'b0;
        total++;
        if (w_read_data1 !== 32'h12345678 || w_read_ready1 !== 1'b1 ||
            w_read_data2 !== 32'hDEADBEEF || w_busy !== 16'h8000) begin
            $display("FAIL wide_bypass: d1=%h r1=%b d2=%h busy=%h, expected 12345678/1/DEADBEEF/8000",
                     w_read_data1, w_read_ready1, w_read_data2, w_busy);
        end else passed++;
        w_write_enable = 1'b1; w_write_addr = 4'd15; w_write_data = 32'h0;
        tick();
        w_write_enable = 1'b0;
        total++;
        if (w_busy !== 16'h0000) begin
            $display("FAIL wide_clear: busy=%h, expected 0000", w_busy);
        end else passed++;
        $display("test_wide: r15=DEADBEEF, r5 bypass -> %h", w_read_data1);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        read_enable = 1'b0; read_addr1 = '0; read_addr2 = '0;
        write_enable = 1'b0; write_addr = '0; write_data = '0;
        rsv_enable = 1'b0; rsv_addr = '0;
        w_read_enable = 1'b0; w_read_addr1 = '0; w_read_addr2 = '0;
        w_write_enable = 1'b0; w_write_addr = '0; w_write_data = '0;
        w_rsv_enable = 1'b0; w_rsv_addr = '0;

        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_async_reset();
        test_wide();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 SHALL have parameter N, default 16, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (power of two, >= 2).
REQ-003 SHALL derive localparam AW = clog2(DEPTH), address width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port read_enable  input  1  capture both read ports this cycle.
REQ-007 SHALL have ports read_addr1, read_addr2  input  AW  read port addresses.
REQ-008 SHALL have ports read_data1, read_data2  output  N  registered read data.
REQ-009 SHALL have ports read_ready1, read_ready2  output  1  registered: captured value is final (no pending write).
REQ-010 SHALL have port write_enable  input  1  commit write_data to write_addr.
REQ-011 SHALL have port write_addr  input  AW  write address.
REQ-012 SHALL have port write_data  input  N  write data.
REQ-013 SHALL have port rsv_enable  input  1  mark rsv_addr as pending-write.
REQ-014 SHALL have port rsv_addr  input  AW  register being reserved.
REQ-015 SHALL have port busy  output  DEPTH  scoreboard bit per register, 1 = pending write.

Function
REQ-016 Write: on rising clk with write_enable=1, regs[write_addr] <= write_data; no effect when write_enable=0.
REQ-017 Read latency 1: on rising clk with read_enable=1, read_dataK <= value of read_addrK, K=1,2; both ports independent, same address allowed.
REQ-018 read_enable=0: read_dataK and read_readyK hold previous values.
REQ-019 Bypass: same-cycle write_enable=1 and write_addr==read_addrK with read_enable=1 -> read_dataK captures write_data, not old contents.
REQ-020 Scoreboard: rsv_enable=1 sets busy[rsv_addr] next edge; write_enable=1 clears busy[write_addr] next edge.
REQ-021 Simultaneous rsv_enable and write_enable to same address -> busy bit SHALL end set (new reservation wins); different addresses -> both take effect.
REQ-022 Reserving an already-busy register SHALL leave it busy; writing a non-busy register SHALL be legal and leave it clear.
REQ-023 read_readyK captured with read_dataK = NOT busy[read_addrK], except a same-cycle write to read_addrK (REQ-019) forces 1, unless same-cycle rsv_enable targets it -> 0.
REQ-024 busy SHALL be a direct register output, no combinational path from inputs.
REQ-025 All addresses full AW range; no out-of-range handling required.

Reset
REQ-026 rst=1 SHALL asynchronously clear all regs, busy, read_data1/2 to 0, and read_ready1/2 to 1.
REQ-027 rst asserted mid-operation SHALL discard same-cycle writes/reservations; first operation honoured on first rising edge after rst deasserts.

Structure
REQ-028 Package reg_file_pkg SHALL hold default N, DEPTH and the clog2 helper; no typedefs otherwise shared.
REQ-029 Scoreboard SHALL be one sub-module reg_scoreboard (DEPTH bits, set/clear ports, priority per REQ-021); storage and bypass stay in reg_file_2r1w.
REQ-030 Storage SHALL be a flat register array with mux read, no tri-state buses.

Verification
REQ-031 Reset then read_enable, addr1=0, addr2=7 -> next cycle read_data1=read_data2=0x0000, both ready=1, busy=0x00.
REQ-032 Write 0xBEEF to r3, next cycle read addr1=3, addr2=3 -> both 0xBEEF one cycle later; read_enable low next cycle -> outputs hold 0xBEEF.
REQ-033 Same cycle write 0x1234 to r5 and read addr1=5 -> read_data1=0x1234, read_ready1=1 next cycle.
REQ-034 rsv r2 -> busy=0x04; read r2 -> read_ready1=0; write r2=0x00AA with rsv r2 same cycle -> busy stays 0x04; later write alone -> busy=0x00.
REQ-035 Write r6=0xFFFF, rsv r1, then assert rst between edges -> all outputs 0 / ready 1, busy=0x00 immediately; read r6 after release -> 0x0000.
REQ-036 Rerun REQ-032/033 with N=32, DEPTH=16 using r15=0xDEADBEEF -> same timing, busy width 16.
